// File: rtl/pipe_chain.sv
// pipe_chain: elastic valid/ready register chain with bubble squeeze and flush; define PIPE_ZERO_BUBBLE_EN to zero data in empty stages
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0] v_q, v_d, en;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH:0]   src_v;
  logic [WIDTH-1:0] src_d [DEPTH+1];
  logic             acc;
  assign src_v     = {v_q, in_valid};
  assign in_ready  = en[0] & !flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  // each stage's source: the input for stage 0, the preceding stage otherwise
  always_comb begin
    src_d[0] = in_data;
    for (int i = 0; i < DEPTH; i++) src_d[i+1] = d_q[i];
  end
  // advance enables ripple from exit to entry; an empty stage always accepts
  always_comb begin
    en  = '0;
    acc = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc   = !v_q[i] | acc;
      en[i] = acc;
    end
  end
  // next stage contents and occupancy of the resulting valid vector
  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = flush ? 1'b0 : en[i] ? src_v[i] : v_q[i];
`ifdef PIPE_ZERO_BUBBLE_EN
      d_d[i] = flush ? '0 : en[i] ? (src_v[i] ? src_d[i] : '0) : d_q[i];
`else
      d_d[i] = (!flush && en[i] && src_v[i]) ? src_d[i] : d_q[i];
`endif
      count_d = count_d + CW'(v_d[i]);
    end
  end
  // stage registers with asynchronous clear of valid, data and count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end
endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised multi-stage pipeline register chain with per-stage valid tracking, an elastic valid/ready handshake, bubble squeezing and a synchronous flush. It replaces the fixed-width, fixed-depth delay registers between datapath stages. Upstream logic presents a beat with `in_valid`, and the downstream stage consumes it with `out_ready`. A stalled consumer backs pressure up only as far as the first empty stage.

## Interface
- `WIDTH`, default 32: data width in bits, 1..64.
- `DEPTH`, default 3: number of register stages, 1..8.
- `CW`, default `$clog2(DEPTH+1)`: occupancy counter width. Derived; do not override.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous clear of all stages.
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: chain accepts the beat this cycle.
- `in_data`, input, `WIDTH`: upstream data.
- `out_valid`, output, 1: exit stage holds a valid beat.
- `out_ready`, input, 1: downstream consumes this cycle.
- `out_data`, output, `WIDTH`: exit stage data.
- `count`, output, `CW`: number of valid stages, registered.

## Operation
- State:
  - Stage `i` holds `v[i]` and `d[i]`. Stage 0 is the entry; stage `DEPTH-1` is the exit.
  - `out_valid = v[DEPTH-1]` and `out_data = d[DEPTH-1]`.
- Advance enables (combinational, computed exit to entry):
  - `en[DEPTH-1] = !v[DEPTH-1] | out_ready`
  - `en[i] = !v[i] | en[i+1]`
  - `in_ready = en[0] & !flush`
- On a clock edge with `flush` = 0, every stage with `en[i]` = 1 loads from its predecessor:
  - `v[i] <= v[i-1]`, `d[i] <= d[i-1]`.
  - Stage 0 loads `in_valid`/`in_data`.
  - A stage with `en[i]` = 0 holds its contents.
- Bubble squeeze: an empty stage always accepts, even while the exit is stalled. A beat therefore advances into gaps until it reaches the first occupied stage.
- Transfer rules:
  - An input transfer occurs iff `in_valid & in_ready`.
  - An output transfer occurs iff `out_valid & out_ready`.
- `flush` = 1:
  - All `v[i]` clear to 0 at the next edge.
  - `in_ready` = 0, so no input is accepted.
  - An output transfer in the flush cycle still counts as consumed. `out_valid` is not masked during flush.
- `count` is the registered population count of the next-state `v`. It always equals the number of valid stages, ranges 0..`DEPTH`, and never wraps.
- No beat is ever duplicated or dropped except by `flush`.

## Timing
- Reset (`reset` = 0, asynchronous):
  - All `v[i]` = 0, all `d[i]` = 0, `count` = 0.
  - Consequently `out_valid` = 0 and `out_data` = 0 immediately.
  - `in_ready` = 1 once `flush` = 0.
- Reset asserted mid-operation discards all beats at once. No transfer completes in the cycle reset is released.
- Latency: a beat accepted at edge N into an empty chain reaches the exit at edge N+`DEPTH`-1. `out_valid` is then high during the cycle after edge N+`DEPTH`-1.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Full chain (`count` = `DEPTH`):
  - `in_ready = out_ready`, a combinational pass-through.
  - A simultaneous input and output transfer keeps `count` at `DEPTH`.
- Empty chain: `in_ready` = 1 regardless of `out_ready`.
- `flush` with simultaneous `in_valid`: the input is not accepted and `count` becomes 0 at the next edge.

## Configuration
- Macro `PIPE_ZERO_BUBBLE_EN`.
- Defined:
  - Any stage that loads an invalid beat, or is cleared by `flush`, sets `d[i]` to 0.
  - `out_data` is 0 whenever `out_valid` = 0. This matches the clear-to-zero behaviour of the earlier delay registers.
- Undefined:
  - A stage loads `d[i]` only when the incoming valid bit is 1; otherwise `d[i]` holds.
  - `flush` clears valid bits only.
  - `out_data` is don't-care when `out_valid` = 0. This reduces data-path toggling.
- Reset clears data in both builds.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with `out_ready` = 1, `DEPTH` = 3 → `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, first appearing 3 cycles after the first accept; `count` peaks at 3.
- Fill with 0xA0..0xA2, hold `out_ready` = 0 → `in_ready` = 0 and `count` = 3. Then pulse `out_ready` for 1 cycle with `in_valid`/0xA3 → `count` stays 3 and the exit becomes 0xA1.
- One beat 0x5 at stage 0 with `out_ready` = 0 and the chain otherwise empty → the beat squeezes to the exit in 2 cycles while `in_ready` stays 1.
- Full chain, assert `flush` with `in_valid` = 1 → `in_ready` = 0, `count` = 0 next cycle, `out_valid` = 0. With `PIPE_ZERO_BUBBLE_EN` defined, `out_data` = 0.
- Pull `reset` low asynchronously between edges with `count` = 2 → `out_valid` and `count` go to 0 before the next edge.
- Random `in_valid`/`out_ready` for 10k cycles at `DEPTH` = 1 and 8 → the scoreboard matches order, no loss, and `count` equals accepted minus consumed.
